// File: rtl/sw_input_pkg.sv
// Register map and CTRL bit positions shared by the switch input peripheral.
package sw_input_pkg;

  typedef enum logic [1:0] {
    REG_CTRL  = 2'd0,
    REG_STATE = 2'd1,
    REG_EDGE  = 2'd2,
    REG_MASK  = 2'd3
  } reg_off_e;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_RISE_EN = 2;
  localparam int CTRL_FALL_EN = 3;
  localparam int CTRL_W       = 4;

endpackage

// File: rtl/sw_debounce.sv
// One input line: 2-FF synchroniser, tick-driven debounce counter and accepted level,
// with single-cycle rise/fall indications in the clock the level changes.
module sw_debounce #(
  parameter int DB_SAMPLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic tick,
  input  logic sw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int                CNT_W   = $clog2(DB_SAMPLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DB_SAMPLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             accept;

  assign differ = (sync_p1 != level);
  assign accept = en && tick && differ && (cnt == CNT_MAX);
  assign rise   = accept && sync_p1;
  assign fall   = accept && !sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
    end else begin
      sync_p0 <= sw;
      sync_p1 <= sync_p0;
      // Disabled: counter parked at zero so re-enabling always needs a full run of ticks.
      if (!en) begin
        cnt <= '0;
      end else if (tick) begin
        if (!differ) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          cnt   <= '0;
          level <= sync_p1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/switch_input_ctrl.sv
// Memory-mapped switch input block: register file, shared sample prescaler,
// per-line debouncers, sticky edge flags and level interrupt.
module switch_input_ctrl
  import sw_input_pkg::*;
#(
  parameter int N_IN       = 32,
  parameter int SAMPLE_DIV = 1000,
  parameter int DB_SAMPLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      addr_i,
  input  logic [31:0]     write_data,
  input  logic            write_en,
  output logic [31:0]     read_data,
  input  logic [N_IN-1:0] sw_i,
  output logic            irq_o
);

  localparam int               PRE_W   = $clog2(SAMPLE_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SAMPLE_DIV - 1);

  logic [CTRL_W-1:0] ctrl;
  logic [N_IN-1:0]   state;
  logic [N_IN-1:0]   edge_flags;
  logic [N_IN-1:0]   mask;
  logic [N_IN-1:0]   rise;
  logic [N_IN-1:0]   fall;
  logic [N_IN-1:0]   edge_set;
  logic [N_IN-1:0]   edge_clr;
  logic [PRE_W-1:0]  pre_cnt;
  logic              tick;
  logic              wr_ctrl;
  logic              wr_edge;
  logic              wr_mask;

  assign tick = ctrl[CTRL_EN] && (pre_cnt == PRE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (!ctrl[CTRL_EN] || pre_cnt == PRE_MAX) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_IN; i++) begin : g_line
    sw_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (ctrl[CTRL_EN]),
      .tick  (tick),
      .sw    (sw_i[i]),
      .level (state[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  assign wr_ctrl  = write_en && (addr_i == REG_CTRL);
  assign wr_edge  = write_en && (addr_i == REG_EDGE);
  assign wr_mask  = write_en && (addr_i == REG_MASK);
  assign edge_set = (rise & {N_IN{ctrl[CTRL_RISE_EN]}}) | (fall & {N_IN{ctrl[CTRL_FALL_EN]}});
  assign edge_clr = wr_edge ? write_data[N_IN-1:0] : '0;

  // Clear is applied before set so a new edge in the same clock as a W1C survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl       <= '0;
      mask       <= '0;
      edge_flags <= '0;
      irq_o      <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= write_data[CTRL_W-1:0];
      if (wr_mask) mask <= write_data[N_IN-1:0];
      edge_flags <= (edge_flags & ~edge_clr) | edge_set;
      irq_o      <= ctrl[CTRL_IRQ_EN] && |(edge_flags & mask);
    end
  end

  always_comb begin
    read_data = '0;
    case (addr_i)
      REG_CTRL:  read_data = 32'(ctrl);
      REG_STATE: read_data = 32'(state);
      REG_EDGE:  read_data = 32'(edge_flags);
      REG_MASK:  read_data = 32'(mask);
      default:   read_data = '0;
    endcase
  end

endmodule

// File: tb/tb_switch_input_ctrl.sv
// Directed bench for switch_input_ctrl with N_IN=8, SAMPLE_DIV=4, DB_SAMPLES=3.
module tb_switch_input_ctrl;

  localparam logic [1:0] A_CTRL = 2'd0, A_STATE = 2'd1, A_EDGE = 2'd2, A_MASK = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  addr_i;
  logic [31:0] write_data;
  logic        write_en;
  logic [31:0] read_data;
  logic [7:0]  sw_i;
  logic        irq_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs [8];

  switch_input_ctrl #(.N_IN(8), .SAMPLE_DIV(4), .DB_SAMPLES(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr_i     (addr_i),
    .write_data (write_data),
    .write_en   (write_en),
    .read_data  (read_data),
    .sw_i       (sw_i),
    .irq_o      (irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] d);
    addr_i = a;
    #1;
    d = read_data;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr_i     = a;
    write_data = d;
    write_en   = 1'b1;
    @(posedge clk);
    #1;
    write_en   = 1'b0;
    write_data = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int n;
    bit found;

    vecs[0] = '{A_CTRL,  32'hFFFF_FFFF, 32'h0000_000F};
    vecs[1] = '{A_CTRL,  32'h0000_0010, 32'h0000_0000};
    vecs[2] = '{A_MASK,  32'hFFFF_FFFF, 32'h0000_00FF};
    vecs[3] = '{A_MASK,  32'h0000_0100, 32'h0000_0000};
    vecs[4] = '{A_STATE, 32'h0000_00FF, 32'h0000_0000};
    vecs[5] = '{A_EDGE,  32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6] = '{A_MASK,  32'h0000_005A, 32'h0000_005A};
    vecs[7] = '{A_CTRL,  32'h0000_0006, 32'h0000_0006};

    rst_n = 1'b0; addr_i = '0; write_data = '0; write_en = 1'b0; sw_i = 8'hFF;
    step(3);
    for (int a = 0; a < 4; a++) begin
      peek(2'(a), d);
      chk($sformatf("reset_read_%0d", a), d, 32'h0);
    end
    chk("reset_irq", 32'(irq_o), 32'h0);
    rst_n = 1'b1;
    wr(A_CTRL, 32'h0);
    step(40);
    peek(A_STATE, d);
    chk("disabled_state", d, 32'h0);

    for (int i = 0; i < 8; i++) begin
      wr(vecs[i].addr, vecs[i].wdata);
      peek(vecs[i].addr, d);
      chk($sformatf("regvec_%0d", i), d, vecs[i].exp);
    end

    // Acceptance: CTRL lands on edge P1; sync high from P3; ticks act at P5, P9, P13.
    sw_i = 8'h00;
    step(3);
    wr(A_MASK, 32'h1);
    wr(A_CTRL, 32'hF);
    sw_i[0] = 1'b1;
    found = 0;
    n = 0;
    while (!found && n < 20) begin
      step(1);
      n++;
      peek(A_STATE, d);
      if (d[0]) found = 1;
    end
    chk("accept_latency", 32'(n), 32'd12);
    peek(A_EDGE, d);
    chk("accept_edge", d, 32'h1);
    chk("accept_irq_same_clk", 32'(irq_o), 32'h0);
    step(1);
    chk("accept_irq_next_clk", 32'(irq_o), 32'h1);

    // Glitch on line 1 spans ticks P17, P21 only; agreeing tick at P25.
    sw_i[1] = 1'b1;
    step(8);
    sw_i[1] = 1'b0;
    step(8);
    peek(A_STATE, d);
    chk("glitch_state", d, 32'h1);
    peek(A_EDGE, d);
    chk("glitch_edge", d, 32'h1);
    sw_i[1] = 1'b1;
    step(10);
    peek(A_STATE, d);
    chk("restart_not_early", d, 32'h1);
    step(1);
    peek(A_STATE, d);
    chk("restart_accept", d, 32'h3);
    peek(A_EDGE, d);
    chk("restart_edge", d, 32'h3);

    wr(A_EDGE, 32'h1);
    peek(A_EDGE, d);
    chk("w1c_partial", d, 32'h2);
    chk("w1c_irq_hold", 32'(irq_o), 32'h1);
    step(1);
    chk("w1c_irq_drop", 32'(irq_o), 32'h0);
    wr(A_EDGE, 32'h2);

    // Fall on line 0 accepted at P57 (FALL_EN on).
    sw_i[0] = 1'b0;
    step(13);
    peek(A_STATE, d);
    chk("fall_state", d, 32'h2);
    peek(A_EDGE, d);
    chk("fall_edge", d, 32'h1);
    step(1);
    chk("fall_irq", 32'(irq_o), 32'h1);
    wr(A_EDGE, 32'h1);

    // Rise on line 0 accepted at P73, same edge as a W1C of bit 0.
    sw_i[0] = 1'b1;
    step(13);
    wr(A_EDGE, 32'h1);
    peek(A_EDGE, d);
    chk("w1c_set_wins", d, 32'h1);
    peek(A_STATE, d);
    chk("w1c_set_state", d, 32'h3);
    step(1);
    chk("set_wins_irq", 32'(irq_o), 32'h1);
    wr(A_EDGE, 32'h1);
    step(1);
    chk("clear_irq", 32'(irq_o), 32'h0);

    // FALL_EN off: fall accepted at P89 without a flag.
    wr(A_CTRL, 32'h7);
    sw_i[0] = 1'b0;
    step(11);
    peek(A_STATE, d);
    chk("nofall_before", d, 32'h3);
    step(1);
    peek(A_STATE, d);
    chk("nofall_state", d, 32'h2);
    peek(A_EDGE, d);
    chk("nofall_edge", d, 32'h0);
    chk("nofall_irq", 32'(irq_o), 32'h0);
    step(1);
    chk("nofall_irq_next", 32'(irq_o), 32'h0);

    // Reset after two disagreeing ticks on line 0 (P93, P97).
    sw_i[0] = 1'b1;
    step(7);
    rst_n = 1'b0;
    peek(A_STATE, d);
    chk("midreset_state", d, 32'h0);
    peek(A_EDGE, d);
    chk("midreset_edge", d, 32'h0);
    peek(A_CTRL, d);
    chk("midreset_ctrl", d, 32'h0);
    chk("midreset_irq", 32'(irq_o), 32'h0);
    step(2);
    rst_n = 1'b1;
    wr(A_MASK, 32'h1);
    wr(A_CTRL, 32'hF);
    step(11);
    peek(A_STATE, d);
    chk("postreset_not_early", d, 32'h0);
    step(1);
    peek(A_STATE, d);
    chk("postreset_state", d, 32'h3);
    peek(A_EDGE, d);
    chk("postreset_edge", d, 32'h3);
    step(1);
    chk("postreset_irq", 32'(irq_o), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
